seq_detect: RTL



---
 rtl/seq_detect_pkg.sv | 17 +
 rtl/sat_counter.sv | 21 ++
 rtl/seq_detect.sv | 119 +++++++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the seq_detect serial pattern detector.
package seq_detect_pkg;

  // FILL: collecting fresh bits before a match is allowed; RUN: every accepted bit is compared.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

  // Width needed for a counter that must reach PAT_LEN inclusive.
  function automatic int fill_w(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  // Count up on inc, hold at all-ones, clear on rst or clr.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_detect.sv
// Serial bit-stream pattern detector with saturating match count.
// Optional feature macro SEQ_DETECT_FIRST_POS_EN adds first_vld/first_pos,
// which capture the stream position of the first match after reset/clear.
module seq_detect
  import seq_detect_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEFAULT_PATTERN),
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 8,
  parameter int                 POS_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_in,
  input  logic             d_valid,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt
`ifdef SEQ_DETECT_FIRST_POS_EN
  ,
  output logic             first_vld,
  output logic [POS_W-1:0] first_pos
`endif
);

  localparam int             FW        = fill_w(PAT_LEN);
  localparam logic [FW-1:0]  FILL_DONE = FW'(PAT_LEN);

  state_t               state_q, state_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [PAT_LEN-1:0]   window_q, window_d;
  logic                 hit_p0;
  logic                 match_p1;

  // Next window, fill count and state; hit_p0 flags a completed pattern on this accepted bit.
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    window_d = window_q;
    hit_p0   = 1'b0;
    if (d_valid) begin
      window_d = {window_q[PAT_LEN-2:0], d_in};
      case (state_q)
        FILL: begin
          fill_d = fill_q + FW'(1);
          if (fill_d == FILL_DONE) begin
            state_d = RUN;
            hit_p0  = (window_d == PATTERN);
          end
        end
        RUN: begin
          hit_p0 = (window_d == PATTERN);
        end
        default: begin
          state_d = FILL;
        end
      endcase
      // Without overlap a match forces a full set of fresh bits before the next one.
      if (hit_p0 && (OVERLAP == 0)) begin
        state_d = FILL;
        fill_d  = '0;
      end
    end
  end

  // State, window and registered match pulse; reset discards any partial window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      fill_q   <= '0;
      window_q <= '0;
      match_p1 <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      window_q <= window_d;
      match_p1 <= hit_p0;
    end
  end

  assign match = match_p1;

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit_p0),
    .clr (clr_cnt),
    .cnt (match_cnt)
  );

`ifdef SEQ_DETECT_FIRST_POS_EN
  logic [POS_W-1:0] pos_cnt;

  sat_counter #(
    .WIDTH(POS_W)
  ) u_pos_cnt (
    .clk (clk),
    .rst (rst),
    .inc (d_valid),
    .clr (1'b0),
    .cnt (pos_cnt)
  );

  // Latch the position of the completing bit on the first match only.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      first_vld <= 1'b0;
      first_pos <= '0;
    end else if (hit_p0 && !first_vld) begin
      first_vld <= 1'b1;
      first_pos <= pos_cnt;
    end
  end
`endif

endmodule
